// File: rtl/regalu_pkg.sv
// Shared constants for the register-file/ALU execution pipe.
// Defines the ALU op width and the op encodings.
package regalu_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_AND = 3'd2;
  localparam logic [OP_W-1:0] OP_OR  = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR = 3'd4;
  localparam logic [OP_W-1:0] OP_SLT = 3'd5;
  localparam logic [OP_W-1:0] OP_SLL = 3'd6;
  localparam logic [OP_W-1:0] OP_SRL = 3'd7;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: op, a, b -> result, zero, ovf.
// ovf is signed overflow for ADD/SUB only; shifts use b's low bits.
module alu_core
  import regalu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              ovf
);

  localparam int SW = $clog2(DATA_W);
  localparam int M  = DATA_W - 1;

  logic [SW-1:0]     sh;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic              lt;

  assign sh   = b[SW-1:0];
  assign sum  = a + b;
  assign diff = a - b;
  assign lt   = $signed(a) < $signed(b);

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    unique case (op)
      OP_ADD: begin
        result = sum;
        ovf = (a[M] == b[M]) && (sum[M] != a[M]);
      end
      OP_SUB: begin
        result = diff;
        ovf = (a[M] != b[M]) && (diff[M] != a[M]);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SLT: result = {{(DATA_W-1){1'b0}}, lt};
      OP_SLL: result = a << sh;
      OP_SRL: result = a >> sh;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/regalu_pipe.sv
// Two-stage regfile/ALU pipe: issue -> EX regs -> OUT regs.
// Ports: issue (in_*), side-band load (ext_*), result (out_*).
module regalu_pipe
  import regalu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NREGS   = 16,
  parameter int ZERO_R0 = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [AW-1:0]     in_rs1,
  input  logic [AW-1:0]     in_rs2,
  input  logic [AW-1:0]     in_rd,
  input  logic              in_we,
  input  logic              ext_we,
  input  logic [AW-1:0]     ext_waddr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [AW-1:0]     out_rd,
  output logic              out_zero,
  output logic              out_ovf
);

  logic [DATA_W-1:0] rf [NREGS];

  logic              ex_valid;
  logic [OP_W-1:0]   ex_op;
  logic [DATA_W-1:0] ex_a;
  logic [DATA_W-1:0] ex_b;
  logic [AW-1:0]     ex_rd;
  logic              ex_we;

  logic [DATA_W-1:0] alu_res;
  logic              alu_zero;
  logic              alu_ovf;

  logic ex_adv;
  logic issue;
  logic wr_ex;
  logic wr_ext;

  logic [AW-1:0]     raddr [2];
  logic [DATA_W-1:0] rval  [2];

  function automatic logic is_r0(
    input logic [AW-1:0] a
  );
    return (ZERO_R0 != 0) && (a == '0);
  endfunction

  alu_core #(.DATA_W(DATA_W)) u_alu (
    .op     (ex_op),
    .a      (ex_a),
    .b      (ex_b),
    .result (alu_res),
    .zero   (alu_zero),
    .ovf    (alu_ovf)
  );

  assign ex_adv   = ex_valid && (!out_valid || out_ready);
  assign in_ready = !ex_valid || ex_adv;
  assign issue    = in_valid && in_ready;

  assign wr_ex  = ex_adv && ex_we && !is_r0(ex_rd);
  assign wr_ext = ext_we && !is_r0(ext_waddr);

  assign raddr[0] = in_rs1;
  assign raddr[1] = in_rs2;

  // The EX op has not written back yet, so its result
  // shadows both the ext load and the stored value.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      if (is_r0(raddr[i]))
        rval[i] = '0;
      else if (ex_valid && ex_we && ex_rd == raddr[i])
        rval[i] = alu_res;
      else if (ext_we && ext_waddr == raddr[i])
        rval[i] = ext_wdata;
      else
        rval[i] = rf[raddr[i]];
    end
  end

  // EX write is last so it wins a same-address clash.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++)
        rf[i] <= '0;
    end else begin
      if (wr_ext)
        rf[ext_waddr] <= ext_wdata;
      if (wr_ex)
        rf[ex_rd] <= alu_res;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid <= 1'b0;
      ex_op    <= '0;
      ex_a     <= '0;
      ex_b     <= '0;
      ex_rd    <= '0;
      ex_we    <= 1'b0;
    end else if (issue) begin
      ex_valid <= 1'b1;
      ex_op    <= in_op;
      ex_a     <= rval[0];
      ex_b     <= rval[1];
      ex_rd    <= in_rd;
      ex_we    <= in_we;
    end else if (ex_adv) begin
      ex_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_rd     <= '0;
      out_zero   <= 1'b0;
      out_ovf    <= 1'b0;
    end else if (ex_adv) begin
      out_valid  <= 1'b1;
      out_result <= alu_res;
      out_rd     <= ex_rd;
      out_zero   <= alu_zero;
      out_ovf    <= alu_ovf;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regalu_pipe.sv
// Randomised + directed bench for regalu_pipe.
// Transaction-level model with per-cycle compare.
module tb_regalu_pipe;
  import regalu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [3:0]  in_rs1;
  logic [3:0]  in_rs2;
  logic [3:0]  in_rd;
  logic        in_we;
  logic        ext_we;
  logic [3:0]  ext_waddr;
  logic [31:0] ext_wdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_rd;
  logic        out_zero;
  logic        out_ovf;

  regalu_pipe #(
    .DATA_W(32), .NREGS(16), .ZERO_R0(1)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_rd(in_rd),
    .in_we(in_we), .ext_we(ext_we),
    .ext_waddr(ext_waddr), .ext_wdata(ext_wdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd),
    .out_zero(out_zero), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  rd;
    logic        we;
    logic        z;
    logic        o;
  } rec_t;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] mrf [16];
  bit   mex_v, mout_v;
  rec_t mex, mout;
  rec_t got [$];

  task automatic chk(string nm,
                     logic [63:0] act,
                     logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic rec_t model_op(
    input logic [2:0]  op,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [3:0]  rd,
    input logic        we
  );
    rec_t   r;
    longint sa, sb, s;
    int     t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0;
    r.rd = rd;
    r.we = we;
    case (op)
      3'd0, 3'd1: begin
        s = (op == 3'd0) ? sa + sb : sa - sb;
        r.res = s[31:0];
        t = int'(s[31:0]);
        r.o = (longint'(t) != s);
      end
      3'd2: r.res = a & b;
      3'd3: r.res = a | b;
      3'd4: r.res = a ^ b;
      3'd5: r.res = (sa < sb) ? 32'd1 : 32'd0;
      3'd6: r.res = a << (b % 32);
      default: r.res = a >> (b % 32);
    endcase
    r.z = (r.res == 0);
    return r;
  endfunction

  function automatic logic [31:0] mread(
    input logic [3:0] a
  );
    if (a == 0) return 32'd0;
    if (mex_v && mex.we && mex.rd == a)
      return mex.res;
    if (ext_we && ext_waddr == a)
      return ext_wdata;
    return mrf[a];
  endfunction

  // Compare + model step, on the falling edge.
  always @(negedge clk) begin
    bit   exp_ready, adv, acc;
    rec_t nop;
    if (!rst) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_result", out_result, 0);
      chk("rst_out_rd", out_rd, 0);
      chk("rst_out_flags", {out_zero, out_ovf}, 0);
      chk("rst_in_ready", in_ready, 1);
      for (int i = 0; i < 16; i++) mrf[i] = '0;
      mex_v = 0;
      mout_v = 0;
    end else begin
      // At most two ops in flight; full only
      // blocks issue when the consumer stalls.
      exp_ready = (int'(mex_v) + int'(mout_v) < 2)
                  || out_ready;
      chk("in_ready", in_ready, exp_ready);
      chk("out_valid", out_valid, mout_v);
      if (mout_v) begin
        chk("out_result", out_result, mout.res);
        chk("out_rd", out_rd, mout.rd);
        chk("out_zero", out_zero, mout.z);
        chk("out_ovf", out_ovf, mout.o);
      end
      if (out_valid && out_ready) begin
        nop = '0;
        nop.res = out_result;
        nop.rd = out_rd;
        nop.z = out_zero;
        nop.o = out_ovf;
        got.push_back(nop);
      end
      adv = mex_v && (!mout_v || out_ready);
      acc = in_valid && exp_ready;
      nop = model_op(in_op, mread(in_rs1),
                     mread(in_rs2), in_rd, in_we);
      if (ext_we && ext_waddr != 0)
        mrf[ext_waddr] = ext_wdata;
      if (adv && mex.we && mex.rd != 0)
        mrf[mex.rd] = mex.res;
      if (mout_v && out_ready) mout_v = 0;
      if (adv) begin
        mout = mex;
        mout_v = 1;
        mex_v = 0;
      end
      if (acc) begin
        mex = nop;
        mex_v = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    in_valid = 0;
    ext_we = 0;
    repeat (n) tick();
  endtask

  task automatic ext_load(logic [3:0] a,
                          logic [31:0] d);
    ext_we = 1;
    ext_waddr = a;
    ext_wdata = d;
    tick();
    ext_we = 0;
  endtask

  task automatic issue(logic [2:0] op,
                       logic [3:0] rs1,
                       logic [3:0] rs2,
                       logic [3:0] rd,
                       logic we,
                       output int stalls);
    bit acc;
    int k;
    in_valid = 1;
    in_op = op;
    in_rs1 = rs1;
    in_rs2 = rs2;
    in_rd = rd;
    in_we = we;
    stalls = 0;
    k = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      tick();
      if (!acc) stalls++;
      k++;
    end while (!acc && k < 100);
    if (!acc) chk("issue_timeout", 0, 1);
    in_valid = 0;
  endtask

  task automatic read_reg(logic [3:0] a);
    int s;
    issue(OP_OR, a, 4'd0, 4'd0, 1'b0, s);
  endtask

  task automatic wait_got(int n, string nm);
    int k = 0;
    while (got.size() < n && k < 60) begin
      tick();
      k++;
    end
    chk(nm, got.size() >= n, 1);
  endtask

  function automatic rec_t gr(int i);
    rec_t r;
    r = '0;
    r.res = 32'hBAD0_BAD0;
    if (i < got.size()) r = got[i];
    return r;
  endfunction

  initial begin
    int s1, s2;
    rst = 0;
    in_valid = 0; in_op = 0;
    in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_we = 0;
    ext_we = 0; ext_waddr = 0; ext_wdata = 0;
    out_ready = 1;
    repeat (3) tick();
    chk("reset_in_ready", in_ready, 1);
    rst = 1;
    tick();

    // load and add
    got.delete();
    ext_load(1, 32'd10);
    ext_load(2, 32'd20);
    issue(OP_ADD, 1, 2, 3, 1, s1);
    tick();
    chk("latency_out_valid", out_valid, 1);
    wait_got(1, "add_seen");
    chk("add_result", gr(0).res, 32'd30);
    chk("add_zero", gr(0).z, 0);
    chk("add_rd", gr(0).rd, 3);
    issue(OP_SUB, 3, 3, 3, 0, s1);
    wait_got(2, "sub_seen");
    chk("sub_result", gr(1).res, 0);
    chk("sub_zero", gr(1).z, 1);

    // back-to-back forwarding
    ext_load(1, 32'd5);
    got.delete();
    issue(OP_ADD, 1, 1, 4, 1, s1);
    issue(OP_ADD, 4, 1, 5, 1, s2);
    wait_got(2, "fwd_seen");
    chk("fwd_first", gr(0).res, 32'd10);
    chk("fwd_second", gr(1).res, 32'd15);
    chk("fwd_no_stall", s1 + s2, 0);
    idle(2);

    // backpressure
    got.delete();
    out_ready = 0;
    fork
      begin
        issue(OP_ADD, 1, 1, 8, 1, s1);
        issue(OP_XOR, 1, 0, 9, 1, s1);
        issue(OP_ADD, 8, 9, 10, 1, s2);
      end
      begin
        repeat (4) tick();
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_none_out", got.size(), 0);
        chk("bp_hold_first", out_result, 32'd10);
        out_ready = 1;
      end
    join
    idle(4);
    chk("bp_count", got.size(), 3);
    chk("bp_r0", gr(0).res, 32'd10);
    chk("bp_r1", gr(1).res, 32'd5);
    chk("bp_r2", gr(2).res, 32'd15);

    // boundaries
    got.delete();
    ext_load(7, 32'hFFFF_FFFF);
    ext_load(8, 32'd1);
    issue(OP_SLT, 7, 8, 0, 0, s1);
    ext_load(9, 32'h7FFF_FFFF);
    issue(OP_ADD, 9, 8, 0, 0, s1);
    ext_load(10, 32'h8000_0000);
    ext_load(11, 32'd31);
    issue(OP_SRL, 10, 11, 0, 0, s1);
    ext_load(12, 32'd33);
    issue(OP_SLL, 8, 12, 0, 0, s1);
    wait_got(4, "bnd_seen");
    chk("slt_neg", gr(0).res, 32'd1);
    chk("add_ovf_res", gr(1).res, 32'h8000_0000);
    chk("add_ovf_flag", gr(1).o, 1);
    chk("srl_31", gr(2).res, 32'd1);
    chk("sll_33", gr(3).res, 32'd2);

    // r0 writes dropped
    got.delete();
    ext_load(0, 32'd7);
    issue(OP_ADD, 1, 1, 0, 1, s1);
    idle(2);
    read_reg(0);
    wait_got(2, "r0_seen");
    chk("r0_op_result", gr(0).res, 32'd10);
    chk("r0_reads_zero", gr(1).res, 0);

    // EX vs ext write to same reg
    got.delete();
    issue(OP_ADD, 1, 1, 6, 1, s1);
    ext_load(6, 32'hDEAD);
    idle(2);
    read_reg(6);
    wait_got(2, "conf_seen");
    chk("conflict_ex_wins", gr(1).res, 32'd10);

    // reset with EX and OUT occupied
    out_ready = 0;
    ext_load(13, 32'd3);
    issue(OP_ADD, 13, 13, 14, 1, s1);
    issue(OP_ADD, 13, 13, 15, 1, s1);
    rst = 0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    tick();
    rst = 1;
    out_ready = 1;
    tick();
    got.delete();
    read_reg(13);
    read_reg(14);
    read_reg(15);
    wait_got(3, "midrst_seen");
    chk("midrst_r13", gr(0).res, 0);
    chk("midrst_r14", gr(1).res, 0);
    chk("midrst_r15", gr(2).res, 0);

    // randomised traffic against the model
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 9) < 6);
      in_op     = 3'($urandom_range(0, 7));
      in_rs1    = 4'($urandom_range(0, 15));
      in_rs2    = 4'($urandom_range(0, 15));
      in_rd     = 4'($urandom_range(0, 15));
      in_we     = ($urandom_range(0, 3) != 0);
      ext_we    = ($urandom_range(0, 9) < 3);
      ext_waddr = 4'($urandom_range(0, 15));
      ext_wdata = ($urandom_range(0, 3) == 0)
                  ? 32'($urandom_range(0, 40))
                  : $urandom;
      out_ready = ($urandom_range(0, 9) < 7);
      rst       = ($urandom_range(0, 499) != 0);
      tick();
    end
    rst = 1;
    out_ready = 1;
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
